// File: rtl/mac_pe.sv
// mac_pe: multiply-accumulate processing element for the systolic matrix array.
// Operand registers feed a product register, which feeds a 32-bit wrapping
// accumulator. Each stage has its own enable, and the operands are forwarded
// to the neighbouring element on o_a_out/o_b_out.
// Build option: define MAC_SIGNED_EN for two's-complement operands, a signed
// product and a sign-extended accumulate. Without it, all arithmetic is
// unsigned with zero-extension.
module mac_pe (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_a_in,
  input  logic [7:0]  i_b_in,
  input  logic        i_load_en,
  input  logic        i_mult_en,
  input  logic        i_acc_en,
  output logic [7:0]  o_a_out,
  output logic [7:0]  o_b_out,
  output logic [31:0] o_acc_out
);

  localparam int DATA_W = 8;
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = 32;

  logic [DATA_W-1:0] r_a_p0;
  logic [DATA_W-1:0] r_b_p0;
  logic [PROD_W-1:0] r_x_p1;
  logic [ACC_W-1:0]  r_acc_p2;
  logic [PROD_W-1:0] w_prod;
  logic [ACC_W-1:0]  w_addend;

  // Full-width product of the two operand registers; no bits are dropped.
  function automatic logic [PROD_W-1:0] mul_full(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
`ifdef MAC_SIGNED_EN
    logic signed [PROD_W-1:0] p;
    p = PROD_W'($signed(a)) * PROD_W'($signed(b));
    return p;
`else
    logic [PROD_W-1:0] p;
    p = PROD_W'(a) * PROD_W'(b);
    return p;
`endif
  endfunction

  // Widen the product to accumulator width (sign- or zero-extended).
  function automatic logic [ACC_W-1:0] widen(input logic [PROD_W-1:0] x);
`ifdef MAC_SIGNED_EN
    logic signed [PROD_W-1:0] xs;
    xs = $signed(x);
    return ACC_W'(xs);
`else
    return ACC_W'(x);
`endif
  endfunction

  assign w_prod   = mul_full(r_a_p0, r_b_p0);
  assign w_addend = widen(r_x_p1);

  // ---- stage p0: operand capture, forwarded to the next element ----
  // Latch a new operand pair when load_en is high; otherwise hold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a_p0 <= '0;
      r_b_p0 <= '0;
    end else if (i_load_en) begin
      r_a_p0 <= i_a_in;
      r_b_p0 <= i_b_in;
    end
  end

  // ---- stage p1: product register ----
  // Capture the product of the pre-edge operands when mult_en is high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x_p1 <= '0;
    end else if (i_mult_en) begin
      r_x_p1 <= w_prod;
    end
  end

  // ---- stage p2: accumulator ----
  // Add the pre-edge product into the accumulator, wrapping modulo 2^32.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc_p2 <= '0;
    end else if (i_acc_en) begin
      r_acc_p2 <= r_acc_p2 + w_addend;
    end
  end

  assign o_a_out   = r_a_p0;
  assign o_b_out   = r_b_p0;
  assign o_acc_out = r_acc_p2;

endmodule

// File: tb/tb_mac_pe.sv
// Testbench for mac_pe: directed steps, with expectations queued at drive time
// and popped when the outputs are sampled.
module tb_mac_pe;

  logic        clk;
  logic        rst_n;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic        load_en;
  logic        mult_en;
  logic        acc_en;
  logic [7:0]  a_out;
  logic [7:0]  b_out;
  logic [31:0] acc_out;

  int n_cmp;
  int n_bad;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  // Reference-model state.
  logic [7:0]  m_a, m_b;
  logic [31:0] m_x;
  logic [31:0] m_acc;

  mac_pe dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_a_in    (a_in),
    .i_b_in    (b_in),
    .i_load_en (load_en),
    .i_mult_en (mult_en),
    .i_acc_en  (acc_en),
    .o_a_out   (a_out),
    .o_b_out   (b_out),
    .o_acc_out (acc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Product already widened to 32 bits, as the accumulator will see it.
  function automatic logic [31:0] model_prod(input logic [7:0] a, input logic [7:0] b);
    int ia, ib;
`ifdef MAC_SIGNED_EN
    ia = int'($signed(a));
    ib = int'($signed(b));
`else
    ia = int'(a);
    ib = int'(b);
`endif
    return 32'(ia * ib);
  endfunction

  task automatic push(input string tag, input logic [31:0] e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_bad++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  // Apply one rising edge, update the model with the same enables, then
  // move to a sampling point 1 time unit after the edge.
  task automatic step();
    logic [31:0] nx, nacc;
    nacc = acc_en  ? m_acc + m_x : m_acc;
    nx   = mult_en ? model_prod(m_a, m_b) : m_x;
    if (load_en) begin
      m_a = a_in;
      m_b = b_in;
    end
    m_x   = nx;
    m_acc = nacc;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b,
                       input logic l, input logic m, input logic c);
    a_in = a; b_in = b; load_en = l; mult_en = m; acc_en = c;
  endtask

  task automatic model_reset();
    m_a = '0; m_b = '0; m_x = '0; m_acc = '0;
  endtask

  task automatic check_all(input string tag);
    push({tag, "_a"}, {24'd0, m_a});
    push({tag, "_b"}, {24'd0, m_b});
    push({tag, "_acc"}, m_acc);
    check({24'd0, a_out});
    check({24'd0, b_out});
    check(acc_out);
  endtask

  initial begin
    longint unsigned wrap_exp;
    n_cmp = 0;
    n_bad = 0;
    model_reset();
    drive(8'h5A, 8'hA5, 1'b1, 1'b1, 1'b1);
    rst_n = 1'b0;

    // Reset held across an edge with every enable high.
    @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Load 5 and 10.
    drive(8'd5, 8'd10, 1'b1, 1'b0, 1'b0);
    step();
    check_all("load");

    // Multiply, then accumulate twice.
    drive(8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    step();
    push("mult_acc_unchanged", 32'd0);
    check(acc_out);
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    step();
    push("acc_first", 32'd50);
    check(acc_out);
    step();
    push("acc_second", 32'd100);
    check(acc_out);

    // Hold with all enables low; one further accumulate proves x held at 50.
    drive(8'd77, 8'd88, 1'b0, 1'b0, 1'b0);
    repeat (5) step();
    check_all("hold");
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    step();
    push("hold_x_kept", 32'd150);
    check(acc_out);

    // Overlapped stages: old operands multiplied while new ones load.
    drive(8'd3, 8'd4, 1'b1, 1'b1, 1'b1);
    step();
    push("pipe_1", 32'd200);
    check(acc_out);
    drive(8'd0, 8'd0, 1'b0, 1'b1, 1'b1);
    step();
    push("pipe_2", 32'd250);
    check(acc_out);
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    step();
    push("pipe_3", 32'd262);
    check(acc_out);

    // Full-throughput stream of random operand pairs.
    for (int i = 0; i < 10; i++) begin
      drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1, 1'b1, 1'b1);
      step();
      check_all($sformatf("stream%0d", i));
    end

    // Asynchronous reset between edges clears everything at once.
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Wrap: 0xFF * 0xFF accumulated 66052 times.
    drive(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    step();
    drive(8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    step();
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    repeat (66052) step();
    wrap_exp = (longint'(model_prod(8'hFF, 8'hFF)) * 64'd66052) & 64'hFFFF_FFFF;
    push("wrap", 32'(wrap_exp));
    check(acc_out);
    push("wrap_model", m_acc);
    check(acc_out);

    // Reset dropped mid-accumulation, between edges.
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Signed-operand case (-3 * 7 under MAC_SIGNED_EN, 253 * 7 otherwise).
    drive(8'hFD, 8'h07, 1'b1, 1'b0, 1'b0);
    step();
    drive(8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    step();
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    step();
`ifdef MAC_SIGNED_EN
    push("signed_mac", 32'hFFFF_FFEB);
`else
    push("signed_mac", 32'd1771);
`endif
    check(acc_out);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
